approx_error_monitor: RTL
=========================

Name: approx_error_monitor

Overview:
- Downstream consumer of the 4x4 approximate multiplier.
- Takes each operand pair (A, B) with the approximate product P, and computes the exact product internally.
- Accumulates error statistics over a window of WINDOW samples: sum of absolute error, maximum absolute error, and count of erroneous samples.
- Presents the statistics as one result on a valid/ready output port. Used for on-chip accuracy characterisation of the multiplier.

Parameters:
WINDOW, 16, samples per measurement window (>=1)
ACC_W, 16, width of the absolute-error sum accumulator (>=8)
CNT_W, $clog2(WINDOW+1), width of the erroneous-sample counter (derived; do not override)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a window; honoured only in IDLE
in_valid  input  1  sample valid
in_ready  output  1  block accepts a sample this cycle
in_a  input  4  operand A
in_b  input  4  operand B
in_p  input  8  approximate product of in_a and in_b
out_valid  output  1  window result valid
out_ready  input  1  downstream accepts result
sum_abs_err  output  ACC_W  saturating sum of abs(exact - in_p) over the window
max_abs_err  output  8  largest abs(exact - in_p) in the window
err_count  output  CNT_W  number of samples with nonzero error
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous): state=IDLE. in_ready=0, out_valid=0, busy=0. sum_abs_err, max_abs_err, err_count, sample counter and pipeline registers all 0.
- States are IDLE, ACCUM, DRAIN, REPORT.
- IDLE -> ACCUM on start=1. The accumulators and the sample counter clear on that edge.
- ACCUM: in_ready=1. A beat is accepted when in_valid & in_ready.
  - Accepted beat, stage 1 (next edge): register exact = in_a*in_b (8-bit unsigned), then d = abs(exact - in_p) (8-bit unsigned, max 255), plus a stage-valid flag.
  - Stage 2 (following edge): sum_abs_err += d, saturating at 2^ACC_W-1 and never wrapping. max_abs_err = max(max_abs_err, d). err_count += (d != 0).
  - Latency from acceptance to the accumulator update is 2 edges. Back-to-back beats are accepted at 1 per cycle.
- ACCUM -> DRAIN on the edge that accepts sample number WINDOW. in_ready drops to 0 in the same cycle as the transition (combinational on state). No extra sample is accepted.
- DRAIN: in_ready=0. Wait until the stage-1 and stage-2 pipeline is empty, i.e. the last sample is folded in. Then go to REPORT. DRAIN lasts exactly 2 cycles.
- REPORT: out_valid=1. Outputs are stable and held while out_ready=0. When out_valid & out_ready, go to IDLE and out_valid=0 next cycle. Statistics outputs keep their values in IDLE until the next start.
- start is ignored in ACCUM, DRAIN and REPORT, including the cycle in which the REPORT handshake completes. A new window needs start asserted while in IDLE.
- in_valid outside ACCUM is ignored; the input is not stalled or buffered.
- Reset asserted mid-window aborts immediately: all state returns to reset values and the partial window is discarded.
- Output registers are visible during ACCUM (running values). Only the values under out_valid are guaranteed.

Test Plan:
- Basic window, WINDOW=4: start, then (a,b,p) = (3,5,15), (15,15,200), (2,2,4), (7,9,70) back-to-back -> out_valid with sum_abs_err=32, max_abs_err=25, err_count=2. in_ready low from the cycle after the 4th accept. out_valid rises 3 cycles after the 4th accept.
- Backpressure: same window with out_ready=0 for 5 cycles -> out_valid and all stats held constant. Handshake on the 6th cycle -> IDLE, busy=0.
- Saturation, ACC_W=8, WINDOW=4: four samples (15,15,0) -> sum_abs_err=255 (saturated, not 132), max_abs_err=225, err_count=4.
- Gapped input and ignored controls: in_valid toggling 1/0 during ACCUM, start pulsed during ACCUM and REPORT -> only valid beats counted, no restart. Results match the basic window.
- Reset mid-window: after 2 accepted samples assert rst for 1 cycle -> all outputs 0, state IDLE. A new start plus 4 exact samples (p=a*b) -> sum=0, max=0, count=0.
- Exact-product sweep, WINDOW=16: samples with p=a*b except one (a,b)=(0,0), p=255 -> sum=255, max=255, count=1.

Source files
------------

// File: rtl/approx_error_monitor.sv
// Accuracy monitor for the 4x4 approximate multiplier: folds |a*b - p| over a
// window of samples into saturating sum, max and error-count statistics.
module approx_error_monitor #(
  parameter int WINDOW = 16,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = $clog2(WINDOW+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic [7:0]       in_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [7:0]       max_abs_err,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             s1_vld_q;
  logic [7:0]       d_q;
  logic [ACC_W-1:0] sum_q;
  logic [7:0]       max_q;
  logic [CNT_W-1:0] errc_q;

  logic             accept;
  logic             last;
  logic [7:0]       exact;
  logic [7:0]       d_d;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_d;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == REPORT);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt_q == CNT_W'(WINDOW-1));

  always_comb begin
    exact   = 8'(in_a) * 8'(in_b);
    d_d     = (exact >= in_p) ? (exact - in_p) : (in_p - exact);
    sum_ext = {1'b0, sum_q} + (ACC_W+1)'(d_q);
    // Carry out of the accumulator means saturate instead of wrapping.
    sum_d   = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      s1_vld_q <= 1'b0;
      d_q      <= '0;
      sum_q    <= '0;
      max_q    <= '0;
      errc_q   <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) d_q <= d_d;

      if (s1_vld_q) begin
        sum_q  <= sum_d;
        if (d_q > max_q) max_q <= d_q;
        errc_q <= errc_q + CNT_W'(d_q != 8'd0);
      end

      case (state_q)
        IDLE: if (start) begin
          state_q <= ACCUM;
          cnt_q   <= '0;
          sum_q   <= '0;
          max_q   <= '0;
          errc_q  <= '0;
        end
        ACCUM: if (accept) begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (last) state_q <= DRAIN;
        end
        // Last sample sits in stage 1 for the first DRAIN cycle and is folded
        // into the accumulators at its end; leave once stage 1 is empty.
        DRAIN:   if (!s1_vld_q) state_q <= REPORT;
        REPORT:  if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sum_abs_err = sum_q;
  assign max_abs_err = max_q;
  assign err_count   = errc_q;

endmodule
